// File: rtl/carfield_pkg.sv
// Shared types and helpers for the Carfield reset/boot-strap sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package carfield_pkg;

  // Cause of the most recent reset, as reported to software.
  typedef enum logic [1:0] {
    RstPor = 2'd0,
    RstSw  = 2'd1,
    RstWdt = 2'd2
  } rst_cause_e;

  // Sequencer phases: strap sampling, reset hold, PHY release delay, normal run.
  typedef enum logic [1:0] {
    StSample = 2'd0,
    StHold   = 2'd1,
    StRelPhy = 2'd2,
    StRun    = 2'd3
  } rst_seq_state_e;

  // Straps are {test_mode, boot_mode[1:0]}.
  localparam int unsigned StrapW = 3;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/carfield_rst_seq_sync.sv
// Two-flop synchronizer for asynchronous strap pads, parametric width.
// Latency: 2 cycles from pad to q_o.
// Backpressure: none; samples every cycle.
module carfield_rst_seq_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, meta_d;
  logic [Width-1:0] sync_q, sync_d;

  // Next values: shift the pad value through two stages.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by the power-on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/carfield_rst_seq.sv
// Reset/boot-strap sequencer in front of the Carfield SoC: strap settle, reset hold, staged PHY release, warm reset.
// Latency: HOLD after SettleCycles stable samples; SoC reset held HoldCycles; PHY released PhyDelayCycles later.
// Backpressure: none; warm requests outside RUN are dropped. CARFIELD_RST_SEQ_WDT_EN enables the watchdog request.
module carfield_rst_seq
  import carfield_pkg::*;
#(
  parameter int unsigned SettleCycles   = 8,
  parameter int unsigned HoldCycles     = 16,
  parameter int unsigned PhyDelayCycles = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] boot_mode_pad_i,
  input  logic       test_mode_pad_i,
  input  logic       sw_rst_req_i,
  input  logic       wdt_rst_req_i,
  output logic       soc_rst_no,
  output logic       hyp_rst_phy_no,
  output logic [1:0] boot_mode_o,
  output logic       test_mode_o,
  output logic [1:0] rst_cause_o,
  output logic       busy_o
);

  // One counter serves all three timed phases, so size it for the longest.
  localparam int unsigned CntW = $clog2(max3(SettleCycles, HoldCycles, PhyDelayCycles) + 1);
  localparam logic [CntW-1:0] SettleMax = CntW'(SettleCycles);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] PhyLast   = CntW'(PhyDelayCycles - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  rst_seq_state_e    state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, settle_cnt;
  logic [StrapW-1:0] sync_q;
  logic [StrapW-1:0] prev_q, prev_d;
  logic              sw_prev_q, sw_prev_d;
  logic [1:0]        boot_mode_q, boot_mode_d;
  logic              test_mode_q, test_mode_d;
  rst_cause_e        rst_cause_q, rst_cause_d;
  logic              soc_rst_n_q, soc_rst_n_d;
  logic              hyp_rst_n_q, hyp_rst_n_d;
  logic              busy_q, busy_d;
  logic              sw_rise;
  logic              wdt_req;

  carfield_rst_seq_sync #(
    .Width(StrapW)
  ) i_strap_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  ({test_mode_pad_i, boot_mode_pad_i}),
    .q_o  (sync_q)
  );

  // Software requests are levels; only a fresh rising edge counts.
  assign sw_rise = sw_rst_req_i & ~sw_prev_q;

`ifdef CARFIELD_RST_SEQ_WDT_EN
  assign wdt_req = wdt_rst_req_i;
`else
  // Watchdog port kept for a stable pinout but has no effect in this build.
  logic unused_wdt;
  assign unused_wdt = wdt_rst_req_i;
  assign wdt_req    = 1'b0;
`endif

  // History registers feeding the strap stability check and SW edge detect.
  always_comb begin
    prev_d    = sync_q;
    sw_prev_d = sw_rst_req_i;
  end

  // Next-state logic: phase timing, strap latching and warm-reset cause.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_cnt  = cnt_q;
    boot_mode_d = boot_mode_q;
    test_mode_d = test_mode_q;
    rst_cause_d = rst_cause_q;
    unique case (state_q)
      StSample: begin
        // Any change on the synchronized straps restarts the settle window.
        if (sync_q != prev_q) begin
          settle_cnt = '0;
        end else if (cnt_q != SettleMax) begin
          settle_cnt = cnt_q + CntOne;
        end
        cnt_d = settle_cnt;
        if (settle_cnt == SettleMax) begin
          state_d                    = StHold;
          cnt_d                      = '0;
          {test_mode_d, boot_mode_d} = sync_q;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StRelPhy;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRelPhy: begin
        if (cnt_q == PhyLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRun: begin
        // Watchdog outranks software; straps stay as latched at power-on.
        if (wdt_req) begin
          state_d     = StHold;
          cnt_d       = '0;
          rst_cause_d = RstWdt;
        end else if (sw_rise) begin
          state_d     = StHold;
          cnt_d       = '0;
          rst_cause_d = RstSw;
        end
      end
      default: begin
        state_d = StSample;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the reset pins are plain flops.
  always_comb begin
    soc_rst_n_d = (state_d == StRelPhy) || (state_d == StRun);
    hyp_rst_n_d = (state_d == StRun);
    busy_d      = (state_d != StRun);
  end

  // State, counter, history and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StSample;
      cnt_q       <= '0;
      prev_q      <= '0;
      sw_prev_q   <= 1'b0;
      boot_mode_q <= 2'b00;
      test_mode_q <= 1'b0;
      rst_cause_q <= RstPor;
      soc_rst_n_q <= 1'b0;
      hyp_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      sw_prev_q   <= sw_prev_d;
      boot_mode_q <= boot_mode_d;
      test_mode_q <= test_mode_d;
      rst_cause_q <= rst_cause_d;
      soc_rst_n_q <= soc_rst_n_d;
      hyp_rst_n_q <= hyp_rst_n_d;
      busy_q      <= busy_d;
    end
  end

  assign soc_rst_no     = soc_rst_n_q;
  assign hyp_rst_phy_no = hyp_rst_n_q;
  assign boot_mode_o    = boot_mode_q;
  assign test_mode_o    = test_mode_q;
  assign rst_cause_o    = rst_cause_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_carfield_rst_seq.sv
// Self-checking bench for carfield_rst_seq: table-driven POR cases, directed warm-reset sequences, random soak.
// Latency: n/a.
// Backpressure: n/a.
module tb_carfield_rst_seq;

  localparam int Settle = 8;
  localparam int Hold   = 16;
  localparam int Phy    = 4;
`ifdef CARFIELD_RST_SEQ_WDT_EN
  localparam bit WdtEn = 1'b1;
`else
  localparam bit WdtEn = 1'b0;
`endif

  logic       clk;
  logic       rst_i;
  logic [1:0] boot_pad;
  logic       test_pad;
  logic       sw;
  logic       wdt;
  logic       soc_n;
  logic       hyp_n;
  logic [1:0] boot_o;
  logic       test_o;
  logic [1:0] cause_o;
  logic       busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  carfield_rst_seq #(
    .SettleCycles  (Settle),
    .HoldCycles    (Hold),
    .PhyDelayCycles(Phy)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .boot_mode_pad_i(boot_pad),
    .test_mode_pad_i(test_pad),
    .sw_rst_req_i   (sw),
    .wdt_rst_req_i  (wdt),
    .soc_rst_no     (soc_n),
    .hyp_rst_phy_no (hyp_n),
    .boot_mode_o    (boot_o),
    .test_mode_o    (test_o),
    .rst_cause_o    (cause_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: time-stamp based. Sampling ends at the first edge whose
  // preceding Settle+1 synchronized strap values are identical; after that the
  // pins are pure functions of (edge - hold_start).
  // ---------------------------------------------------------------------------
  bit         m_ok   = 1'b0;
  bit         m_samp = 1'b1;
  int         m_t    = 0;
  int         m_k    = 0;
  int         m_h    = 0;
  logic [2:0] m_syn[$];
  logic [2:0] m_last_pad = 3'b000;
  logic [2:0] m_latched  = 3'b000;
  int         m_cause    = 0;
  bit         m_sw_prev  = 1'b0;

  function automatic bit window_stable();
    if (m_syn.size() != Settle + 1) return 1'b0;
    foreach (m_syn[i]) if (m_syn[i] != m_syn[0]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic       r, s, w;
    logic [2:0] pad;
    bit         e_soc, e_hyp;
    int         exp_v, act_v;
    forever begin
      @(posedge clk);
      r   = rst_i;
      pad = {test_pad, boot_pad};
      s   = sw;
      w   = wdt;
      m_t++;
      if (r) begin
        m_ok      = 1'b1;
        m_samp    = 1'b1;
        m_k       = 0;
        m_latched = 3'b000;
        m_cause   = 0;
        m_syn.delete();
        m_syn.push_back(3'b000);
        m_syn.push_back(3'b000);
      end else if (m_ok) begin
        m_k++;
        if (m_samp) begin
          if (window_stable()) begin
            m_samp    = 1'b0;
            m_h       = m_t;
            m_latched = m_syn[m_syn.size()-1];
          end
          m_syn.push_back((m_k == 1) ? 3'b000 : m_last_pad);
          if (m_syn.size() > Settle + 1) void'(m_syn.pop_front());
        end else if (m_t - 1 >= m_h + Hold + Phy) begin
          if (WdtEn && w) begin
            m_h     = m_t;
            m_cause = 2;
          end else if (s && !m_sw_prev) begin
            m_h     = m_t;
            m_cause = 1;
          end
        end
      end
      m_last_pad = pad;
      m_sw_prev  = r ? 1'b0 : s;
      #1;
      if (m_ok) begin
        e_soc = !m_samp && (m_t >= m_h + Hold);
        e_hyp = !m_samp && (m_t >= m_h + Hold + Phy);
        exp_v = int'({e_soc, e_hyp, m_latched[1:0], m_latched[2], 2'(m_cause), !e_hyp});
        act_v = int'({soc_n, hyp_n, boot_o, test_o, cause_o, busy_o});
        chk("model {soc,hyp,boot,test,cause,busy}", act_v, exp_v);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0] boot;
    logic       test;
    logic       glitch;
    logic [1:0] gval;
    int         lat_e;
    int         soc_e;
    int         hyp_e;
  } por_vec_t;

  por_vec_t tbl[6];

  task automatic por(input logic [1:0] b, input logic t);
    rst_i    = 1'b1;
    boot_pad = b;
    test_pad = t;
    sw       = 1'b0;
    wdt      = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int soc_e, hyp_e, lat_e, bsy_e, relow;
    rst_i    = 1'b1;
    boot_pad = 2'b00;
    test_pad = 1'b0;
    sw       = 1'b0;
    wdt      = 1'b0;

    tbl[0] = '{2'b10, 1'b0, 1'b0, 2'b00, 11, 27, 31};
    tbl[1] = '{2'b00, 1'b0, 1'b0, 2'b00,  0, 24, 28};
    tbl[2] = '{2'b11, 1'b1, 1'b0, 2'b00, 11, 27, 31};
    tbl[3] = '{2'b01, 1'b0, 1'b1, 2'b10, 17, 33, 37};
    tbl[4] = '{2'b00, 1'b1, 1'b0, 2'b00, 11, 27, 31};
    tbl[5] = '{2'b00, 1'b0, 1'b1, 2'b11,  0, 33, 37};

    repeat (2) @(negedge clk);

    // Power-on sequences from the table; glitch rows flip boot pads for edge 6 only.
    for (int r = 0; r < 6; r++) begin
      por(tbl[r].boot, tbl[r].test);
      lat_e = 0; soc_e = 0; hyp_e = 0; bsy_e = 0;
      for (int e = 1; e <= 45; e++) begin
        boot_pad = (tbl[r].glitch && e == 6) ? tbl[r].gval : tbl[r].boot;
        @(posedge clk); #1;
        if (lat_e == 0 && {test_o, boot_o} != 3'b000) lat_e = e;
        if (soc_e == 0 && soc_n)   soc_e = e;
        if (hyp_e == 0 && hyp_n)   hyp_e = e;
        if (bsy_e == 0 && !busy_o) bsy_e = e;
        @(negedge clk);
      end
      chk($sformatf("por%0d latch edge", r), lat_e, tbl[r].lat_e);
      chk($sformatf("por%0d soc rise edge", r), soc_e, tbl[r].soc_e);
      chk($sformatf("por%0d hyp rise edge", r), hyp_e, tbl[r].hyp_e);
      chk($sformatf("por%0d busy fall edge", r), bsy_e, tbl[r].hyp_e);
      chk($sformatf("por%0d boot_mode", r), int'(boot_o), int'(tbl[r].boot));
      chk($sformatf("por%0d test_mode", r), int'(test_o), int'(tbl[r].test));
      chk($sformatf("por%0d cause", r), int'(cause_o), 0);
    end

    // Software warm reset at edge N, with the request level then held high.
    por(2'b10, 1'b0);
    wait_edges(35);
    sw = 1'b1;
    @(posedge clk); #1;
    chk("sw soc low at N", int'(soc_n), 0);
    chk("sw hyp low at N", int'(hyp_n), 0);
    chk("sw busy at N", int'(busy_o), 1);
    chk("sw cause", int'(cause_o), 1);
    soc_e = 0; hyp_e = 0; relow = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (soc_e == 0 && soc_n) soc_e = k;
      if (hyp_e == 0 && hyp_n) hyp_e = k;
      if (soc_e != 0 && !soc_n) relow++;
    end
    chk("sw soc rise offset", soc_e, Hold);
    chk("sw hyp rise offset", hyp_e, Hold + Phy);
    chk("sw held no retrigger", relow, 0);
    chk("sw boot kept", int'(boot_o), 2);
    @(negedge clk);
    sw = 1'b0;
    wait_edges(3);

    // Simultaneous SW edge and WDT pulse.
    sw  = 1'b1;
    wdt = 1'b1;
    @(posedge clk); #1;
    chk("both cause", int'(cause_o), WdtEn ? 2 : 1);
    chk("both soc low", int'(soc_n), 0);
    @(negedge clk);
    wdt = 1'b0;
    wait_edges(25);
    sw = 1'b0;
    wait_edges(3);

    // Watchdog-only pulse.
    wdt = 1'b1;
    @(posedge clk); #1;
    chk("wdt only soc", int'(soc_n), WdtEn ? 0 : 1);
    chk("wdt only busy", int'(busy_o), WdtEn ? 1 : 0);
    chk("wdt only cause", int'(cause_o), WdtEn ? 2 : 1);
    @(negedge clk);
    wdt = 1'b0;
    wait_edges(25);

    // Warm reset, then power-on reset asserted while in HOLD.
    sw = 1'b1;
    wait_edges(9);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("rst in hold outputs {soc,hyp,boot,test,cause,busy}",
        int'({soc_n, hyp_n, boot_o, test_o, cause_o, busy_o}), 1);
    @(negedge clk);
    rst_i = 1'b0;
    sw    = 1'b0;
    soc_e = 0; hyp_e = 0; relow = 0;
    for (int e = 1; e <= 50; e++) begin
      sw  = (e >= 15);
      wdt = (e == 20);
      @(posedge clk); #1;
      if (soc_e == 0 && soc_n) soc_e = e;
      if (hyp_e == 0 && hyp_n) hyp_e = e;
      if (soc_e != 0 && !soc_n) relow++;
      @(negedge clk);
    end
    chk("restart soc rise edge", soc_e, 27);
    chk("restart hyp rise edge", hyp_e, 31);
    chk("requests in hold dropped", relow, 0);
    chk("restart cause", int'(cause_o), 0);
    sw  = 1'b0;
    wdt = 1'b0;

    // Random soak against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_i = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 11) == 0) {test_pad, boot_pad} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) sw = ~sw;
      wdt = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    rst_i = 1'b0;
    sw    = 1'b0;
    wdt   = 1'b0;
    wait_edges(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "time limit");
  end

endmodule
